// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use, redirect and busy-hold controller with watchdog and event counters
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_BUSY = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_wr,
  input  logic             ex_branch_taken,
  input  logic             ex_busy,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             ID_EX_Write,
  output logic             busy_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] busy_cnt
);

  localparam int RUN_W = $clog2(MAX_BUSY) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BUSY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN, HOLD, REDIRECT} state_t;

  state_t           state, state_next;
  logic [RUN_W-1:0] run_cnt, run_next;
  logic             lu, br;
  logic             inc_stall, inc_flush, inc_busy, set_timeout;

  // Hazard decode, priority resolution (br > busy > lu) and pipeline control outputs
  always_comb begin
    lu = id_ex_MemRead && (id_ex_wr != 5'd0) &&
         ((id_ex_wr == if_id_rs1) || (if_id_uses_rs2 && (id_ex_wr == if_id_rs2)));
    // EX holds the bubble while redirecting, so a stale taken flag there is ignored
    br = ex_branch_taken && (state != REDIRECT);

    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_Flush    = 1'b0;
    ID_Flush    = 1'b0;
    ID_EX_Write = 1'b1;
    state_next  = RUN;
    run_next    = '0;
    inc_stall   = 1'b0;
    inc_flush   = 1'b0;
    inc_busy    = 1'b0;
    set_timeout = 1'b0;

    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_Flush    = 1'b1;
      ID_Flush    = 1'b1;
    end else if (br) begin
      IF_Flush   = 1'b1;
      ID_Flush   = 1'b1;
      state_next = REDIRECT;
      inc_flush  = 1'b1;
    end else if (ex_busy) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      state_next  = HOLD;
      inc_busy    = 1'b1;
      run_next    = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
      // This busy cycle brings the consecutive run up to the limit
      set_timeout = (run_cnt >= RUN_MAX - RUN_W'(1));
    end else if (lu) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_Flush    = 1'b1;
      inc_stall   = 1'b1;
    end
  end

  // State, watchdog run length, sticky timeout and saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      run_cnt      <= '0;
      busy_timeout <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      busy_cnt     <= '0;
    end else begin
      state        <= state_next;
      run_cnt      <= run_next;
      busy_timeout <= busy_timeout | set_timeout;
      if (inc_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (inc_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (inc_busy  && (busy_cnt  != CNT_MAX)) busy_cnt  <= busy_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl against a rule-level model
module tb_pipe_hazard_ctrl;

  localparam int CW = 2;
  localparam int MB = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    if_id_rs1, if_id_rs2, id_ex_wr;
  logic          if_id_uses_rs2, id_ex_MemRead, ex_branch_taken, ex_busy;
  logic          PCWrite, IF_ID_Write, IF_Flush, ID_Flush, ID_EX_Write, busy_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, busy_cnt;

  pipe_hazard_ctrl #(.CNT_W(CW), .MAX_BUSY(MB)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_wr(id_ex_wr),
    .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush),
    .ID_Flush(ID_Flush), .ID_EX_Write(ID_EX_Write), .busy_timeout(busy_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Expected: controls {PCWrite,IF_ID_Write,IF_Flush,ID_Flush,ID_EX_Write} this cycle, registers after the edge
  typedef struct {
    logic [4:0] ctl;
    int         stall, flush, busy;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: only "was last cycle a redirect" and the busy run length matter
  bit m_redirect;
  int m_run, m_stall, m_flush, m_busy;
  bit m_to;

  function automatic int sat_inc(int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input int rs1, input int rs2, input bit u2,
                      input bit mr, input int wr, input bit bt, input bit bz);
    exp_t e;
    bit   lu, br;
    @(negedge clk);
    rst = r; if_id_rs1 = 5'(rs1); if_id_rs2 = 5'(rs2); if_id_uses_rs2 = u2;
    id_ex_MemRead = mr; id_ex_wr = 5'(wr); ex_branch_taken = bt; ex_busy = bz;
    lu = mr && (wr != 0) && ((wr == rs1) || (u2 && wr == rs2));
    br = bt && !m_redirect;
    if (r) begin
      e.ctl = 5'b00111;
      m_redirect = 0; m_run = 0; m_stall = 0; m_flush = 0; m_busy = 0; m_to = 0;
    end else if (br) begin
      e.ctl = 5'b11111;
      m_flush = sat_inc(m_flush); m_run = 0; m_redirect = 1;
    end else if (bz) begin
      e.ctl = 5'b00000;
      m_busy = sat_inc(m_busy);
      m_run = (m_run < MB) ? m_run + 1 : m_run;
      if (m_run >= MB) m_to = 1;
      m_redirect = 0;
    end else if (lu) begin
      e.ctl = 5'b00011;
      m_stall = sat_inc(m_stall); m_run = 0; m_redirect = 0;
    end else begin
      e.ctl = 5'b11001;
      m_run = 0; m_redirect = 0;
    end
    e.stall = m_stall; e.flush = m_flush; e.busy = m_busy; e.to = m_to;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 1, 2, 0, 0, 0, 0, 0);
  endtask

  // Monitor: controls sampled late in the low phase, registers just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("PCWrite",     PCWrite,     e.ctl[4]);
        check("IF_ID_Write", IF_ID_Write, e.ctl[3]);
        check("IF_Flush",    IF_Flush,    e.ctl[2]);
        check("ID_Flush",    ID_Flush,    e.ctl[1]);
        check("ID_EX_Write", ID_EX_Write, e.ctl[0]);
        @(posedge clk);
        #1;
        check("stall_cnt",    stall_cnt,    e.stall);
        check("flush_cnt",    flush_cnt,    e.flush);
        check("busy_cnt",     busy_cnt,     e.busy);
        check("busy_timeout", busy_timeout, e.to);
      end
    end
  end

  initial begin
    int wait_cyc;
    m_redirect = 0; m_run = 0; m_stall = 0; m_flush = 0; m_busy = 0; m_to = 0;
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1, $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom), 1'($urandom),
           $urandom_range(0, 31), 1'($urandom), 1'($urandom));
    idle();
    // Load-use through rs2, then the non-stalling variants
    step(0, 1, 5, 1, 1, 5, 0, 0);
    step(0, 1, 5, 0, 1, 5, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    idle();
    // Two-cycle taken branch: second cycle is the ignored REDIRECT
    step(0, 1, 2, 0, 0, 0, 1, 0);
    step(0, 1, 2, 0, 0, 0, 1, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Branch coincident with load-use
    step(0, 7, 3, 1, 1, 7, 1, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Busy hold for 3 cycles
    for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 0, 0, 0, 1);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Watchdog: 6 busy cycles, flag must survive the release
    for (int i = 0; i < 6; i++) step(0, 1, 2, 0, 0, 0, 0, 1);
    idle(); idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Stall counter saturation
    for (int i = 0; i < 5; i++) begin
      step(0, 9, 4, 0, 1, 9, 0, 0);
      idle();
    end
    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 3),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 45);
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and flush controller for the 5-stage RISC-V core. It produces the ID_Flush bubble request consumed by the ID/EX register, plus the IF-side stall and flush controls. It resolves load-use hazards, taken-branch/jump redirects from EX, and multi-cycle EX holds with a busy watchdog. It keeps saturating event counters for debug.

## Interface
Parameters:
- CNT_W, 32, width of each event counter
- MAX_BUSY, 64, maximum consecutive ex_busy cycles before timeout (must be ≥ 1)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- if_id_rs1  in  5  rs1 field of the instruction in ID
- if_id_rs2  in  5  rs2 field of the instruction in ID
- if_id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types)
- id_ex_MemRead  in  1  instruction in EX is a load
- id_ex_wr  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- ex_busy  in  1  multi-cycle EX operation not yet complete
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register update enable
- IF_Flush  out  1  zero the IF/ID register
- ID_Flush  out  1  load a bubble into ID/EX
- ID_EX_Write  out  1  ID/EX update enable (0 = hold)
- busy_timeout  out  1  sticky error flag
- stall_cnt, flush_cnt, busy_cnt  out  CNT_W each  saturating event counters

## Operation
- FSM states: RUN, HOLD, REDIRECT. Reset state is RUN.
- Hazard terms, evaluated combinationally:
  - lu = id_ex_MemRead & (id_ex_wr != 0) & ((id_ex_wr == if_id_rs1) | (if_id_uses_rs2 & id_ex_wr == if_id_rs2))
  - br = ex_branch_taken & (state != REDIRECT)
- Priority is br > ex_busy > lu.
- br (any state except REDIRECT):
  - Outputs: IF_Flush=1, ID_Flush=1, PCWrite=1 (redirect target loads), IF_ID_Write=1.
  - Next state: REDIRECT. flush_cnt += 1. Busy run counter cleared.
- ex_busy without br:
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, both flushes 0.
  - Next state: HOLD. busy_cnt += 1. Busy run counter += 1.
- lu without br or ex_busy:
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_Flush=1, ID_EX_Write=1.
  - Next state: RUN. stall_cnt += 1.
- None of the above:
  - Outputs: all enables 1, all flushes 0.
  - Next state: RUN. Busy run counter cleared.
- REDIRECT lasts exactly one cycle:
  - ex_branch_taken is ignored, because EX holds the bubble.
  - ex_busy and lu are still evaluated.
  - Next state: HOLD if ex_busy, else RUN.
- HOLD exits to RUN in the first cycle ex_busy=0. That cycle's outputs follow the lu/none rules.
- Watchdog:
  - A busy run counter (width clog2(MAX_BUSY)+1) counts consecutive ex_busy cycles.
  - When it reaches MAX_BUSY, busy_timeout sets to 1 and stays set until rst.
  - The stall continues while ex_busy=1; the flag is observational only.
- All counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- PCWrite, IF_ID_Write, IF_Flush, ID_Flush and ID_EX_Write are combinational from state and inputs: zero latency in the same cycle.
- State, counters and busy_timeout update on the rising clk edge and are visible the next cycle.
- During rst=1, outputs are forced to:
  - PCWrite=0, IF_ID_Write=0, IF_Flush=1, ID_Flush=1, ID_EX_Write=1.
- On the edge with rst=1:
  - state←RUN; counters, busy run counter and busy_timeout←0.
- Reset mid-HOLD or mid-REDIRECT abandons the operation; the first post-reset cycle is RUN.
- A load-use stall always lasts exactly one cycle. The next cycle the load is in MEM and lu deasserts naturally; no state is kept for it.
- br and lu in the same cycle: flush wins. stall_cnt is unchanged and flush_cnt increments.

## Test plan
- Reset: hold rst 2 cycles with random inputs. Required during reset: IF_Flush=1, ID_Flush=1, PCWrite=0. After release: all counters 0, busy_timeout=0, state RUN.
- Load-use: id_ex_MemRead=1, id_ex_wr=5, if_id_rs2=5, if_id_uses_rs2=1 for one cycle. Required: PCWrite=0, IF_ID_Write=0, ID_Flush=1; stall_cnt=1. Repeat with if_id_uses_rs2=0 or id_ex_wr=0: no stall.
- Branch redirect: ex_branch_taken=1 for 2 consecutive cycles. Cycle 1: IF_Flush=1, ID_Flush=1. Cycle 2 (REDIRECT): no flush. flush_cnt=1.
- Branch with load-use in the same cycle: flush outputs only; flush_cnt=1, stall_cnt=0.
- Busy hold: ex_busy=1 for 3 cycles, then 0. Required: PCWrite=IF_ID_Write=ID_EX_Write=0 for 3 cycles, then all 1. busy_cnt=3, busy_timeout=0.
- Watchdog and saturation: with MAX_BUSY=4, hold ex_busy for 6 cycles. busy_timeout rises after the 4th busy edge and stays 1 after ex_busy drops. With CNT_W=2, trigger 5 load-use stalls: stall_cnt=3.
